uart_rx_fifo: RTL and testbench

//  Receive buffer directly downstream of UartRX. Watches UartRX.out; on each

---
 rtl/uart_pkg.sv | 18 +
 rtl/fifo_sync.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive buffer and the transmitter.
//   UART_IDLE      : bus word meaning "no byte available"
//   UART_READY_BIT : bit that is low while a received byte is being presented
//   uart_byte_t    : one UART payload byte
//   rearm_state_t  : re-arm handshake state of the receive buffer
package uart_pkg;

  localparam logic [15:0] UART_IDLE      = 16'h8000;
  localparam int          UART_READY_BIT = 15;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    ARMED    = 1'b0,
    CLEARING = 1'b1
  } rearm_state_t;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with distributed-RAM storage and a combinational head.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointers only)
//   push, din  : write request and data; accepted when not full, or when a
//                pop is accepted in the same cycle
//   pop        : read request; accepted when not empty
//   dout       : head entry (valid only while !empty)
//   empty/full : status flags
//   count      : entries held, 0..DEPTH
module fifo_sync #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // The extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop frees the slot the simultaneous push lands in, so full+pop may push.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign dout = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; it is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer sitting directly behind UartRX.
// Captures each byte UartRX presents, queues it, and pulses rx_clear for one
// cycle afterwards to re-arm the receiver. The CPU polls a 16-bit read word
// that uses the same 16'h8000 "nothing available" encoding as UartRX.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   rx_out     : UartRX.out (16'h8000 idle, {8'h00,byte} when a byte is ready)
//   rx_clear   : registered one-cycle re-arm pulse to UartRX.clear
//   rd         : CPU pop strobe
//   out        : 16'h8000 when empty, else {8'h00, head byte}
//   count      : bytes held, 0..DEPTH
//   overflow   : sticky, set when a byte is dropped on a full FIFO
//   clr_ovf    : clears overflow; a drop in the same cycle takes priority
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       rx_out,
  output logic              rx_clear,
  input  logic              rd,
  output logic [15:0]       out,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  rearm_state_t rearm_p1;
  rearm_state_t rearm_p0;
  logic         capture;
  logic         drop;
  logic         empty;
  logic         full;
  uart_byte_t   head;
  logic         unused_rx_hi;

  // Only the ready bit and the payload byte carry information.
  assign unused_rx_hi = ^rx_out[14:8];

  // While clearing, UartRX still shows the byte just taken; ignore it so each
  // frame is pushed exactly once.
  assign capture = !rx_out[UART_READY_BIT] && (rearm_p1 == ARMED);

  // When full, a same-cycle rd makes room, so only a push without rd is lost.
  assign drop = capture && full && !rd;

  // ---- stage p0 -> p1: re-arm state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) rearm_p1 <= ARMED;
    else        rearm_p1 <= rearm_p0;
  end

  always_comb begin
    rearm_p0 = ARMED;
    case (rearm_p1)
      ARMED:    rearm_p0 = capture ? CLEARING : ARMED;
      CLEARING: rearm_p0 = ARMED;
      default:  rearm_p0 = ARMED;
    endcase
  end

  assign rx_clear = (rearm_p1 == CLEARING);

  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  fifo_sync #(
    .WIDTH  (8),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (rd),
    .din   (rx_out[7:0]),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always_comb begin
    out = UART_IDLE;
    if (!empty) out = {8'h00, head};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo with a queue-based reference model and a
// behavioural UartRX holding register driven by the expected re-arm pulse.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       rx_out;
  logic              rx_clear;
  logic              rd;
  logic [15:0]       out;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_out   (rx_out),
    .rx_clear (rx_clear),
    .rd       (rd),
    .out      (out),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference state: bytes held, sticky flag, expected re-arm pulse this cycle,
  // and the word the UartRX model is presenting.
  byte unsigned q[$];
  bit           m_ovf = 1'b0;
  bit           m_clr = 1'b0;
  logic [15:0]  uart_hold = 16'h8000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  // f/b: a new serial frame carrying b completes this cycle (lands in UartRX).
  task automatic tick(input bit r, input bit c, input bit f, input byte unsigned b);
    bit cap, pop, was_full, n_clr;
    rx_out  = uart_hold;
    rd      = r;
    clr_ovf = c;
    #1;
    if (chk_en) begin
      chk("out", {16'h0, out}, (q.size() == 0) ? 32'h8000 : {24'h0, q[0]});
      chk("count", {27'h0, count}, q.size());
      chk("rx_clear", {31'h0, rx_clear}, {31'h0, m_clr});
      chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    end
    @(posedge clk);
    n_clr = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      cap      = !uart_hold[15] && !m_clr;
      pop      = r && (q.size() > 0);
      was_full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (was_full && !pop) m_ovf = 1'b1;
        else                  q.push_back(uart_hold[7:0]);
      end
      if (!(cap && was_full && !pop) && c) m_ovf = 1'b0;
      n_clr = cap;
    end
    // UartRX is not reset by rst_n; it only reacts to the clear pulse.
    if (m_clr)                         uart_hold = 16'h8000;
    else if (f && uart_hold[15])       uart_hold = {8'h00, b};
    m_clr = n_clr;
    #1;
  endtask

  task automatic send(input byte unsigned b);
    tick(1'b0, 1'b0, 1'b1, b);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; clr_ovf = 1'b0; rx_out = 16'h8000;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    idle(2);

    // Single byte, held two cycles by UartRX, then read back.
    send(8'h41);
    chk("single_count", {27'h0, count}, 32'd1);
    drain(1);
    idle(1);

    // Full stream in order, twice so the pointers wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 16; i++) send(8'(i));
      chk("stream_full", {27'h0, count}, 32'd16);
      drain(16);
      idle(1);
    end

    // Overflow: 17th byte dropped, still re-armed; clr_ovf clears the flag.
    for (int i = 0; i < 17; i++) send(8'(8'h20 + i));
    chk("ovf_set", {31'h0, overflow}, 32'd1);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    drain(16);
    idle(1);

    // Capture and rd together when full, then when empty.
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i));
    tick(1'b0, 1'b0, 1'b1, 8'hAA);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("full_rd_cap", {27'h0, count}, 32'd16);
    drain(16);
    idle(1);
    tick(1'b0, 1'b0, 1'b1, 8'h55);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("empty_rd_cap", {27'h0, count}, 32'd1);
    drain(1);
    idle(1);

    // Reset during the clearing cycle with bytes queued.
    for (int i = 0; i < 3; i++) send(8'(8'h90 + i));
    tick(1'b0, 1'b0, 1'b1, 8'h77);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic with varying read pressure, clears and resets.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 800; i++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        tick(($urandom_range(0, 9) < 2 + 2 * ph),
             ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 1) == 1),
             8'($urandom));
      end
    end
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
